registro_tabuleiro: RTL
=======================

Name: registro_tabuleiro

Overview:
Board-state register for the tic-tac-toe game: the inverse end of the button-to-binary conversion path. It accepts a move as a binary position code (1..9) plus player, decodes it back to one-hot, validates it, and stores it in per-player board registers. It also detects wins and draws, and drives a blinking LED marker for the last accepted move. It sits between the game control unit and the board LED and display outputs.

Parameters:
PISCA_CICLOS, 25000000, clock cycles per half-period of the last-move blink (0.5 s at 50 MHz); minimum 1.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; all state cleared while low
limpa  in  1  synchronous board clear (new game)
jogada_valida  in  1  move strobe, sampled each rising edge
posicao  in  4  binary position code, 1..9 valid
jogador  in  1  0 = O, 1 = X
tab_x  out  9  one-hot board occupancy for X (bit k = position k+1)
tab_o  out  9  one-hot board occupancy for O
aceita  out  1  one-cycle pulse: move stored
erro  out  1  one-cycle pulse: move rejected
codigo_erro  out  2  01 invalid code, 10 occupied, 11 game over; holds until next aceita/erro/limpa
vencedor  out  2  00 none, 01 X, 10 O
empate  out  1  board full, no winner
led_ultima  out  9  blinking one-hot of last accepted position

Behaviour:
- Reset (reset=0, async): tab_x=tab_o=0, aceita=erro=0, codigo_erro=00, vencedor=00, empate=0, led_ultima=0, blink counter=0, blink phase=1, last-move register=0.
- Decode: posicao 1..9 -> bit (posicao-1) set; 0 and 10..15 -> invalid.
- Combinational terms from registered boards: ganha_x / ganha_o = any of the 8 lines (3 rows, 3 columns, 2 diagonals) fully set; cheio = (tab_x|tab_o)==9'h1FF; fim = ganha_x|ganha_o|cheio.
- Per rising edge, priority order:
  1. limpa=1: boards, last-move register, codigo_erro, vencedor and empate cleared; aceita=erro=0; jogada_valida ignored.
  2. jogada_valida=1 with invalid code: erro=1, codigo_erro=01.
  3. jogada_valida=1, fim=1: erro=1, codigo_erro=11. Code-invalid check takes precedence.
  4. jogada_valida=1, target bit set in tab_x|tab_o: erro=1, codigo_erro=10.
  5. Otherwise: set bit in tab_x (jogador=1) or tab_o (jogador=0); aceita=1; last-move register <= one-hot; blink counter <= 0; phase <= 1.
  6. No strobe: aceita=erro=0.
- aceita and erro are never high in the same cycle. A strobe held high for N cycles is evaluated N times; repeats are rejected as occupied.
- vencedor and empate are registered from the board state: valid one cycle after the aceita edge. Blocking (rule 3) uses the combinational fim and therefore takes effect on the very next edge. Both winner lines set is unreachable; if it occurs, X has priority.
- Blink: the counter counts 0..PISCA_CICLOS-1. On wrap, the phase toggles. led_ultima = last-move register when phase=1, else 0. The counter runs continuously while the last-move register is nonzero, and holds at 0 otherwise.
- Counter width is $clog2(PISCA_CICLOS+1). No overflow beyond the wrap.

Test Plan:
- Reset then move: reset low, then high; strobe posicao=5, jogador=1 -> aceita pulse; tab_x=9'h010, tab_o=0; led_ultima=9'h010 immediately.
- Invalid and occupied: strobe posicao=0 -> erro, codigo_erro=01; strobe 12 -> 01; strobe 5 again with jogador=0 -> erro, codigo_erro=10; boards unchanged.
- Win and lockout: X plays 1, 2, 3 (O plays 4, 5 in between) -> one cycle after the third X aceita, vencedor=01. A strobe on the very next edge (posicao=9) -> erro, codigo_erro=11.
- Draw: fill in the order X1 O2 X3 O5 X4 O6 X8 O7 X9 -> tab_x=9'h18D, tab_o=9'h072, empate=1, vencedor=00.
- Blink with PISCA_CICLOS=4: after aceita at position 7, led_ultima=9'h040 for 4 cycles, then 0 for 4, repeating. A new aceita mid-period restarts phase=1.
- Priority and reset: limpa and jogada_valida high together -> boards 0, no aceita/erro. reset pulled low mid-blink (asynchronously, between edges) -> all outputs 0 immediately.

Source files
------------

// File: rtl/registro_tabuleiro.sv
// Tic-tac-toe board register: decodes a binary move, validates it,
// stores it per player, flags win/draw and blinks the last move.
module registro_tabuleiro #(
   parameter int PISCA_CICLOS = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       limpa,
   input  logic       jogada_valida,
   input  logic [3:0] posicao,
   input  logic       jogador,
   output logic [8:0] tab_x,
   output logic [8:0] tab_o,
   output logic       aceita,
   output logic       erro,
   output logic [1:0] codigo_erro,
   output logic [1:0] vencedor,
   output logic       empate,
   output logic [8:0] led_ultima
);

   localparam int CW = $clog2(PISCA_CICLOS + 1);
   localparam logic [CW-1:0] CMAX = CW'(PISCA_CICLOS - 1);

   logic [8:0]    onehot;
   logic          cod_ok;
   logic          ganha_x;
   logic          ganha_o;
   logic          cheio;
   logic          fim;
   logic          ocupado;
   logic          aceitar;
   logic [8:0]    ultima;
   logic [CW-1:0] cnt;
   logic          fase;

   function automatic logic linha(input logic [8:0] t);
      return (t[0] & t[1] & t[2]) | (t[3] & t[4] & t[5]) |
             (t[6] & t[7] & t[8]) | (t[0] & t[3] & t[6]) |
             (t[1] & t[4] & t[7]) | (t[2] & t[5] & t[8]) |
             (t[0] & t[4] & t[8]) | (t[2] & t[4] & t[6]);
   endfunction

   always_comb begin
      onehot = '0;
      cod_ok = 1'b0;
      if (posicao >= 4'd1 && posicao <= 4'd9) begin
         cod_ok = 1'b1;
         onehot = 9'd1 << (posicao - 4'd1);
      end
   end

   assign ganha_x = linha(tab_x);
   assign ganha_o = linha(tab_o);
   assign cheio   = (tab_x | tab_o) == 9'h1FF;
   assign fim     = ganha_x | ganha_o | cheio;
   assign ocupado = |(onehot & (tab_x | tab_o));
   assign aceitar = ~limpa & jogada_valida & cod_ok & ~fim & ~ocupado;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tab_x       <= '0;
         tab_o       <= '0;
         aceita      <= 1'b0;
         erro        <= 1'b0;
         codigo_erro <= 2'b00;
         vencedor    <= 2'b00;
         empate      <= 1'b0;
         ultima      <= '0;
      end else if (limpa) begin
         tab_x       <= '0;
         tab_o       <= '0;
         aceita      <= 1'b0;
         erro        <= 1'b0;
         codigo_erro <= 2'b00;
         vencedor    <= 2'b00;
         empate      <= 1'b0;
         ultima      <= '0;
      end else begin
         aceita <= 1'b0;
         erro   <= 1'b0;
         if (jogada_valida) begin
            if (!cod_ok) begin
               erro        <= 1'b1;
               codigo_erro <= 2'b01;
            end else if (fim) begin
               erro        <= 1'b1;
               codigo_erro <= 2'b11;
            end else if (ocupado) begin
               erro        <= 1'b1;
               codigo_erro <= 2'b10;
            end else begin
               aceita      <= 1'b1;
               codigo_erro <= 2'b00;
               ultima      <= onehot;
               if (jogador) tab_x <= tab_x | onehot;
               else         tab_o <= tab_o | onehot;
            end
         end
         // X wins ties on the unreachable double-win board
         if (ganha_x)      vencedor <= 2'b01;
         else if (ganha_o) vencedor <= 2'b10;
         else              vencedor <= 2'b00;
         empate <= cheio & ~ganha_x & ~ganha_o;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         fase <= 1'b1;
      end else if (limpa || aceitar) begin
         cnt  <= '0;
         fase <= 1'b1;
      end else if (ultima == '0) begin
         cnt <= '0;
      end else if (cnt == CMAX) begin
         cnt  <= '0;
         fase <= ~fase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign led_ultima = fase ? ultima : '0;

endmodule
